// File: rtl/mcdec_pkg.sv
// Shared constants and types for the multi-cycle MIPS control decoder.
package mcdec_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned ALU_W   = 3;

  // Primary opcodes (instr[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_BLTZ  = 6'b000001;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  // R-type function codes (instr[5:0])
  localparam logic [FUNCT_W-1:0] FN_MFHI  = 6'b010000;
  localparam logic [FUNCT_W-1:0] FN_MFLO  = 6'b010010;
  localparam logic [FUNCT_W-1:0] FN_MULTU = 6'b011001;
  localparam logic [FUNCT_W-1:0] FN_ADDU  = 6'b100001;
  localparam logic [FUNCT_W-1:0] FN_SUBU  = 6'b100011;
  localparam logic [FUNCT_W-1:0] FN_AND   = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR    = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_SLTU  = 6'b101011;

  // ALU operation codes
  localparam logic [ALU_W-1:0] ALU_SLTU  = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUBU  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_BLTZ  = 3'b010;
  localparam logic [ALU_W-1:0] ALU_LUI   = 3'b011;
  localparam logic [ALU_W-1:0] ALU_MULTU = 3'b100;
  localparam logic [ALU_W-1:0] ALU_ADDU  = 3'b101;
  localparam logic [ALU_W-1:0] ALU_OR    = 3'b110;
  localparam logic [ALU_W-1:0] ALU_AND   = 3'b111;

  localparam logic [REG_W-1:0] REG_RA = 5'd31;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MUL    = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    CLS_NONE   = 4'd0,
    CLS_ALU    = 4'd1,
    CLS_MUL    = 4'd2,
    CLS_IMM    = 4'd3,
    CLS_LOAD   = 4'd4,
    CLS_STORE  = 4'd5,
    CLS_BRANCH = 4'd6,
    CLS_JUMP   = 4'd7,
    CLS_JAL    = 4'd8
  } op_class_t;

  // Destination register: rd for R-type, $ra for JAL, rt otherwise.
  function automatic logic [REG_W-1:0] dest_sel(input logic [OP_W-1:0]  op,
                                                input logic [REG_W-1:0] rt,
                                                input logic [REG_W-1:0] rd);
    if (op == OP_RTYPE)    return rd;
    else if (op == OP_JAL) return REG_RA;
    else                   return rt;
  endfunction

endpackage

// File: rtl/multicycle_decoder_alu_op_decode.sv
// Combinational {op, funct} -> {alucontrol, instruction class, legal}.
module alu_op_decode
  import mcdec_pkg::*;
#(
  parameter int unsigned ALUCTRL_W = 3
) (
  input  logic [OP_W-1:0]      op,
  input  logic [FUNCT_W-1:0]   funct,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output op_class_t            cls,
  output logic                 legal
);

  logic [ALU_W-1:0] code;

  // Classify the instruction and pick its ALU operation.
  always_comb begin
    code  = '0;
    cls   = CLS_NONE;
    legal = 1'b1;
    case (op)
      OP_RTYPE: begin
        cls = CLS_ALU;
        case (funct)
          FN_ADDU:  code = ALU_ADDU;
          FN_SUBU:  code = ALU_SUBU;
          FN_AND:   code = ALU_AND;
          FN_OR:    code = ALU_OR;
          FN_SLTU:  code = ALU_SLTU;
          FN_MFHI:  code = ALU_ADDU;
          FN_MFLO:  code = ALU_ADDU;
          FN_MULTU: begin
            code = ALU_MULTU;
            cls  = CLS_MUL;
          end
          default: begin
            cls   = CLS_NONE;
            legal = 1'b0;
          end
        endcase
      end
      OP_ADDIU: begin code = ALU_ADDU; cls = CLS_IMM;    end
      OP_LUI:   begin code = ALU_LUI;  cls = CLS_IMM;    end
      OP_ORI:   begin code = ALU_OR;   cls = CLS_IMM;    end
      OP_LW:    begin code = ALU_ADDU; cls = CLS_LOAD;   end
      OP_SW:    begin code = ALU_ADDU; cls = CLS_STORE;  end
      OP_BEQ:   begin code = ALU_SUBU; cls = CLS_BRANCH; end
      OP_BLTZ:  begin code = ALU_BLTZ; cls = CLS_BRANCH; end
      OP_J:     begin                  cls = CLS_JUMP;   end
      OP_JAL:   begin code = ALU_ADDU; cls = CLS_JAL;    end
      default:  legal = 1'b0;
    endcase
  end

  assign alucontrol = ALUCTRL_W'(code);

endmodule

// File: rtl/multicycle_decoder.sv
// Multi-cycle MIPS control sequencer: fetch / decode / execute / memory / writeback.
// Optional build macro MCDEC_TRAP_EN adds the 'illegal' output and a sticky trap state.
module multicycle_decoder
  import mcdec_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned ALUCTRL_W  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instr,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 irwrite,
  output logic                 pcwrite,
  output logic                 memread,
  output logic                 memwrite,
  output logic                 memtoreg,
  output logic                 alusrcbimm,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 dobranch,
  output logic                 dojump,
  output logic                 regwrite,
  output logic [4:0]           destreg,
  output logic                 hilowrite,
  output logic                 busy
`ifdef MCDEC_TRAP_EN
  ,
  output logic                 illegal
`endif
);

  localparam int unsigned CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  state_t               state, state_nxt;
  logic [OP_W-1:0]      op_q;
  logic [FUNCT_W-1:0]   funct_q;
  logic [REG_W-1:0]     dest_q;
  logic [CNT_W-1:0]     mul_cnt;
  logic                 mul_load;

  logic [ALUCTRL_W-1:0] dec_alu;
  op_class_t            dec_cls;
  logic                 dec_legal;

  // rs and shamt fields are not needed for control generation.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[25:21], instr[10:6]};

  alu_op_decode #(
    .ALUCTRL_W (ALUCTRL_W)
  ) u_alu_op_decode (
    .op         (op_q),
    .funct      (funct_q),
    .alucontrol (dec_alu),
    .cls        (dec_cls),
    .legal      (dec_legal)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // Capture opcode, funct and destination once the IR holds the new word.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= '0;
      funct_q <= '0;
      dest_q  <= '0;
    end else if (state == S_DECODE) begin
      op_q    <= instr[31:26];
      funct_q <= instr[5:0];
      dest_q  <= dest_sel(instr[31:26], instr[20:16], instr[15:11]);
    end
  end

  // MULTU occupancy counter: loaded on entry to S_MUL, counts down to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_cnt <= '0;
    end else if (mul_load) begin
      mul_cnt <= CNT_W'(MUL_CYCLES - 1);
    end else if (state == S_MUL && mul_cnt != '0) begin
      mul_cnt <= mul_cnt - CNT_W'(1);
    end
  end

  // Next-state and control outputs; everything is forced low while reset is high.
  always_comb begin
    state_nxt  = state;
    mul_load   = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    memtoreg   = 1'b0;
    alusrcbimm = 1'b0;
    alucontrol = '0;
    dobranch   = 1'b0;
    dojump     = 1'b0;
    regwrite   = 1'b0;
    destreg    = '0;
    hilowrite  = 1'b0;
    busy       = 1'b0;
`ifdef MCDEC_TRAP_EN
    illegal    = 1'b0;
`endif
    if (!reset) begin
      busy = (state != S_FETCH);
      case (state)
        S_FETCH: begin
          memread = 1'b1;
          if (mem_ready) begin
            irwrite   = 1'b1;
            pcwrite   = 1'b1;
            state_nxt = S_DECODE;
          end
        end

        S_DECODE: state_nxt = S_EXEC;

        S_EXEC: begin
          if (!dec_legal) begin
`ifdef MCDEC_TRAP_EN
            state_nxt = S_TRAP;
`else
            state_nxt = S_FETCH;
`endif
          end else begin
            case (dec_cls)
              CLS_ALU: begin
                alucontrol = dec_alu;
                state_nxt  = S_WB;
              end
              CLS_MUL: begin
                alucontrol = dec_alu;
                mul_load   = 1'b1;
                state_nxt  = S_MUL;
              end
              CLS_IMM: begin
                alucontrol = dec_alu;
                alusrcbimm = 1'b1;
                state_nxt  = S_WB;
              end
              CLS_LOAD, CLS_STORE: begin
                alucontrol = dec_alu;
                alusrcbimm = 1'b1;
                state_nxt  = S_MEM;
              end
              CLS_BRANCH: begin
                alucontrol = dec_alu;
                dobranch   = zero;
                state_nxt  = S_FETCH;
              end
              CLS_JUMP: begin
                dojump    = 1'b1;
                state_nxt = S_FETCH;
              end
              CLS_JAL: begin
                alucontrol = dec_alu;
                dojump     = 1'b1;
                regwrite   = 1'b1;
                destreg    = REG_RA;
                state_nxt  = S_FETCH;
              end
              default: state_nxt = S_FETCH;
            endcase
          end
        end

        S_MUL: begin
          alucontrol = dec_alu;
          if (mul_cnt == '0) begin
            hilowrite = 1'b1;
            state_nxt = S_FETCH;
          end
        end

        S_MEM: begin
          alucontrol = dec_alu;
          alusrcbimm = 1'b1;
          if (dec_cls == CLS_LOAD) memread  = 1'b1;
          else                     memwrite = 1'b1;
          if (mem_ready) begin
            state_nxt = (dec_cls == CLS_LOAD) ? S_WB : S_FETCH;
          end
        end

        S_WB: begin
          regwrite  = 1'b1;
          destreg   = dest_q;
          memtoreg  = (dec_cls == CLS_LOAD);
          state_nxt = S_FETCH;
        end

`ifdef MCDEC_TRAP_EN
        S_TRAP: begin
          illegal   = 1'b1;
          state_nxt = S_TRAP;
        end
`endif

        default: state_nxt = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_decoder.sv
// Directed bench for multicycle_decoder: per-cycle expected outputs are queued, then
// replayed against the DUT and checked mid-cycle.
module tb_multicycle_decoder;

  localparam int unsigned MUL_CYCLES = 4;
  localparam int unsigned ALUCTRL_W  = 3;

  localparam logic [2:0] A_SLTU = 3'b000;
  localparam logic [2:0] A_SUBU = 3'b001;
  localparam logic [2:0] A_BLTZ = 3'b010;
  localparam logic [2:0] A_LUI  = 3'b011;
  localparam logic [2:0] A_MUL  = 3'b100;
  localparam logic [2:0] A_ADDU = 3'b101;
  localparam logic [2:0] A_OR   = 3'b110;

  typedef struct packed {
    logic       irwrite;
    logic       pcwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrcbimm;
    logic [2:0] alucontrol;
    logic       dobranch;
    logic       dojump;
    logic       regwrite;
    logic [4:0] destreg;
    logic       hilowrite;
    logic       busy;
    logic       illegal;
  } outs_t;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        irwrite, pcwrite, memread, memwrite, memtoreg, alusrcbimm;
  logic [ALUCTRL_W-1:0] alucontrol;
  logic        dobranch, dojump, regwrite, hilowrite, busy;
  logic [4:0]  destreg;
  logic        illegal;
`ifndef MCDEC_TRAP_EN
  assign illegal = 1'b0;
`endif

  multicycle_decoder #(
    .MUL_CYCLES (MUL_CYCLES),
    .ALUCTRL_W  (ALUCTRL_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .irwrite    (irwrite),
    .pcwrite    (pcwrite),
    .memread    (memread),
    .memwrite   (memwrite),
    .memtoreg   (memtoreg),
    .alusrcbimm (alusrcbimm),
    .alucontrol (alucontrol),
    .dobranch   (dobranch),
    .dojump     (dojump),
    .regwrite   (regwrite),
    .destreg    (destreg),
    .hilowrite  (hilowrite),
    .busy       (busy)
`ifdef MCDEC_TRAP_EN
    ,
    .illegal    (illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  outs_t got;
  always_comb begin
    got.irwrite    = irwrite;
    got.pcwrite    = pcwrite;
    got.memread    = memread;
    got.memwrite   = memwrite;
    got.memtoreg   = memtoreg;
    got.alusrcbimm = alusrcbimm;
    got.alucontrol = alucontrol;
    got.dobranch   = dobranch;
    got.dojump     = dojump;
    got.regwrite   = regwrite;
    got.destreg    = destreg;
    got.hilowrite  = hilowrite;
    got.busy       = busy;
    got.illegal    = illegal;
  end

  outs_t q_exp[$];
  bit    q_rst[$];
  bit    q_rdy[$];
  bit    q_z[$];
  string q_tag[$];

  int n_cmp = 0;
  int n_err = 0;

  function automatic outs_t o_fetch(input logic rdy);
    outs_t e = '0;
    e.memread = 1'b1;
    e.irwrite = rdy;
    e.pcwrite = rdy;
    return e;
  endfunction

  function automatic outs_t o_busy();
    outs_t e = '0;
    e.busy = 1'b1;
    return e;
  endfunction

  function automatic outs_t o_ex(input logic [2:0] alu, input logic bimm);
    outs_t e = o_busy();
    e.alucontrol = alu;
    e.alusrcbimm = bimm;
    return e;
  endfunction

  function automatic outs_t o_wb(input logic [4:0] dst, input logic mtr);
    outs_t e = o_busy();
    e.regwrite = 1'b1;
    e.destreg  = dst;
    e.memtoreg = mtr;
    return e;
  endfunction

  task automatic push(input bit rst, input bit rdy, input bit z, input outs_t e, input string tag);
    q_rst.push_back(rst);
    q_rdy.push_back(rdy);
    q_z.push_back(z);
    q_exp.push_back(e);
    q_tag.push_back(tag);
  endtask

  // Replay queued cycles: drive inputs just after posedge, compare at negedge.
  task automatic run();
    outs_t e;
    string t;
    while (q_exp.size() > 0) begin
      reset     = q_rst.pop_front();
      mem_ready = q_rdy.pop_front();
      zero      = q_z.pop_front();
      @(negedge clk);
      e = q_exp.pop_front();
      t = q_tag.pop_front();
      n_cmp++;
      assert (got === e) else begin
        n_err++;
        $error("FAIL %s: observed %b expected %b", t, got, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic seq_rimm(input logic [31:0] w, input logic [2:0] alu, input logic bimm,
                          input logic [4:0] dst, input string tag);
    instr = w;
    push(0, 1, 0, o_fetch(1), {tag, "_fetch"});
    push(0, 1, 0, o_busy(), {tag, "_dec"});
    push(0, 1, 0, o_ex(alu, bimm), {tag, "_exec"});
    push(0, 1, 0, o_wb(dst, 0), {tag, "_wb"});
    run();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    outs_t e;
    reset = 1'b1; instr = '0; zero = 1'b0; mem_ready = 1'b0;

    // Power-on reset.
    push(1, 0, 0, '0, "rst0");
    push(1, 1, 1, '0, "rst1");
    run();

    // SW $2,4($1) aborted by reset while waiting in S_MEM.
    instr = 32'hAC220004;
    push(0, 1, 0, o_fetch(1), "sw_abort_fetch");
    push(0, 0, 0, o_busy(), "sw_abort_dec");
    push(0, 0, 0, o_ex(A_ADDU, 1), "sw_abort_exec");
    e = o_ex(A_ADDU, 1); e.memwrite = 1'b1;
    push(0, 0, 0, e, "sw_abort_mem_wait");
    push(1, 0, 0, '0, "rst_mid_0");
    push(1, 0, 0, '0, "rst_mid_1");
    push(0, 0, 0, o_fetch(0), "post_rst_fetch");
    run();

    // ADDU $3,$1,$2
    seq_rimm(32'h00221821, A_ADDU, 0, 5'd3, "addu");

    // LW $5,4($1) with three wait cycles in S_MEM.
    instr = 32'h8C250004;
    push(0, 1, 0, o_fetch(1), "lw_fetch");
    push(0, 1, 0, o_busy(), "lw_dec");
    push(0, 1, 0, o_ex(A_ADDU, 1), "lw_exec");
    e = o_ex(A_ADDU, 1); e.memread = 1'b1;
    push(0, 0, 0, e, "lw_mem_wait0");
    push(0, 0, 0, e, "lw_mem_wait1");
    push(0, 0, 0, e, "lw_mem_wait2");
    push(0, 1, 0, e, "lw_mem_done");
    push(0, 1, 0, o_wb(5'd5, 1), "lw_wb");
    run();

    // MULTU $1,$2: S_MUL occupies MUL_CYCLES cycles, hilowrite on the last.
    instr = 32'h00220019;
    push(0, 1, 0, o_fetch(1), "multu_fetch");
    push(0, 1, 0, o_busy(), "multu_dec");
    push(0, 1, 0, o_ex(A_MUL, 0), "multu_exec");
    push(0, 1, 0, o_ex(A_MUL, 0), "multu_mul0");
    push(0, 1, 0, o_ex(A_MUL, 0), "multu_mul1");
    push(0, 1, 0, o_ex(A_MUL, 0), "multu_mul2");
    e = o_ex(A_MUL, 0); e.hilowrite = 1'b1;
    push(0, 1, 0, e, "multu_mul_last");
    run();

    // BEQ taken (zero=1), then not taken (zero=0).
    instr = 32'h10220003;
    push(0, 1, 1, o_fetch(1), "beq1_fetch");
    push(0, 1, 1, o_busy(), "beq1_dec");
    e = o_ex(A_SUBU, 0); e.dobranch = 1'b1;
    push(0, 1, 1, e, "beq1_exec");
    push(0, 1, 1, o_fetch(1), "beq2_fetch");
    push(0, 1, 1, o_busy(), "beq2_dec");
    push(0, 1, 0, o_ex(A_SUBU, 0), "beq2_exec");
    run();

    // BLTZ $1 with zero=1.
    instr = 32'h04200002;
    push(0, 1, 0, o_fetch(1), "bltz_fetch");
    push(0, 1, 0, o_busy(), "bltz_dec");
    e = o_ex(A_BLTZ, 0); e.dobranch = 1'b1;
    push(0, 1, 1, e, "bltz_exec");
    run();

    // JAL: jump plus link write to $31 in a single cycle.
    instr = 32'h0C000010;
    push(0, 1, 0, o_fetch(1), "jal_fetch");
    push(0, 1, 0, o_busy(), "jal_dec");
    e = o_ex(A_ADDU, 0); e.dojump = 1'b1; e.regwrite = 1'b1; e.destreg = 5'd31;
    push(0, 1, 0, e, "jal_exec");
    run();

    // J: jump only.
    instr = 32'h08000010;
    push(0, 1, 0, o_fetch(1), "j_fetch");
    push(0, 1, 0, o_busy(), "j_dec");
    e = o_busy(); e.dojump = 1'b1;
    push(0, 1, 0, e, "j_exec");
    run();

    // Immediate forms and more R-type functions.
    seq_rimm(32'h24240005, A_ADDU, 1, 5'd4, "addiu");
    seq_rimm(32'h3C061234, A_LUI,  1, 5'd6, "lui");
    seq_rimm(32'h342800FF, A_OR,   1, 5'd8, "ori");
    seq_rimm(32'h00223823, A_SUBU, 0, 5'd7, "subu");
    seq_rimm(32'h0022482B, A_SLTU, 0, 5'd9, "sltu");

    // SW $2,4($1) completing after one wait cycle.
    instr = 32'hAC220004;
    push(0, 1, 0, o_fetch(1), "sw_fetch");
    push(0, 1, 0, o_busy(), "sw_dec");
    push(0, 1, 0, o_ex(A_ADDU, 1), "sw_exec");
    e = o_ex(A_ADDU, 1); e.memwrite = 1'b1;
    push(0, 0, 0, e, "sw_mem_wait");
    push(0, 1, 0, e, "sw_mem_done");
    run();

    // Undefined opcode 0x3F.
    instr = 32'hFC000000;
    push(0, 1, 0, o_fetch(1), "undef_fetch");
    push(0, 1, 0, o_busy(), "undef_dec");
    push(0, 1, 0, o_busy(), "undef_exec");
`ifdef MCDEC_TRAP_EN
    e = o_busy(); e.illegal = 1'b1;
    for (int i = 0; i < 10; i++) push(0, 1, 1, e, "trap_hold");
    push(1, 1, 0, '0, "trap_reset");
    push(0, 0, 0, o_fetch(0), "trap_exit_fetch");
`else
    push(0, 0, 0, o_fetch(0), "nop_next_fetch");
    push(0, 0, 0, o_fetch(0), "nop_fetch_hold");
`endif
    run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
